// File: rtl/imm_ext_pkg.sv
// Shared types and helpers for the LC-3 immediate/offset extension queue.
// Optional feature macro: IMM_EXT_ZEXT_EN (enables the TRAP8 zero-extend mode).
package imm_ext_pkg;

  // Field widths of the LC-3 immediate and offset encodings.
  localparam int IMM5_W    = 5;
  localparam int OFF6_W    = 6;
  localparam int PCOFF9_W  = 9;
  localparam int PCOFF11_W = 11;
  localparam int TRAP8_W   = 8;

  // Field-select encodings; 5..7 are never legal.
  typedef enum logic [2:0] {
    MODE_IMM5    = 3'd0,
    MODE_OFF6    = 3'd1,
    MODE_PCOFF9  = 3'd2,
    MODE_PCOFF11 = 3'd3,
    MODE_TRAP8   = 3'd4
  } imm_mode_e;

  // True when the mode selects a field this build knows how to extend.
  function automatic logic mode_is_legal(input logic [2:0] mode);
    logic legal_s;
    case (mode)
      3'd0, 3'd1, 3'd2, 3'd3: legal_s = 1'b1;
`ifdef IMM_EXT_ZEXT_EN
      3'd4:                   legal_s = 1'b1;
`else
      3'd4:                   legal_s = 1'b0;
`endif
      default:                legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/imm_ext_fifo.sv
// Generic in-order FIFO with occupancy count. DEPTH must be a power of two
// so the pointers wrap naturally; push when full and pop when empty are
// ignored so a misbehaving neighbour cannot corrupt the pointers.
module imm_ext_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 19,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage: cleared on reset so the head reads zero while empty.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Write and read pointers, each advancing on its own accepted operation.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy: unchanged when a push and a pop land together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_queue.sv
// Buffered LC-3 immediate/offset extension unit. Extracts the field chosen
// by in_mode, sign- or zero-extends it to DATA_W bits and queues the result
// with its mode tag so decode and the ALU/address consumers stall independently.
// Optional feature macro: IMM_EXT_ZEXT_EN (mode 4, TRAP8 zero-extension).
module imm_ext_queue
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_ir,
  input  logic [2:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [2:0]                 out_mode,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int ENTRY_W = DATA_W + 3;

  logic [DATA_W-1:0]          ext_s;
  logic                       legal_s;
  logic                       fire_s;
  logic                       push_s;
  logic                       bad_beat_s;
  logic                       pop_s;
  logic                       full_s;
  logic                       empty_s;
  logic [ENTRY_W-1:0]         rdata_s;
  logic [$clog2(DEPTH+1)-1:0] count_s;
  logic                       ready_en_r;
  logic                       err_r;
  logic                       unused_ir_s;

  // IR[15:11] never feeds any extension field.
  assign unused_ir_s = &{1'b0, in_ir[15:11]};

  // Field extraction and extension; sign extension comes from the signed cast.
  always_comb begin
    ext_s = '0;
    case (imm_mode_e'(in_mode))
      MODE_IMM5:    ext_s = DATA_W'($signed(in_ir[IMM5_W-1:0]));
      MODE_OFF6:    ext_s = DATA_W'($signed(in_ir[OFF6_W-1:0]));
      MODE_PCOFF9:  ext_s = DATA_W'($signed(in_ir[PCOFF9_W-1:0]));
      MODE_PCOFF11: ext_s = DATA_W'($signed(in_ir[PCOFF11_W-1:0]));
`ifdef IMM_EXT_ZEXT_EN
      MODE_TRAP8:   ext_s = DATA_W'(in_ir[TRAP8_W-1:0]);
`endif
      default:      ext_s = '0;
    endcase
  end

  // Handshake glue: illegal beats complete the handshake but are dropped.
  assign legal_s    = mode_is_legal(in_mode);
  assign in_ready   = ready_en_r && !full_s;
  assign fire_s     = in_valid && in_ready;
  assign push_s     = fire_s && legal_s;
  assign bad_beat_s = fire_s && !legal_s;
  assign out_valid  = !empty_s;
  assign pop_s      = out_valid && out_ready;

  // Holds in_ready low during reset and for the cycle of its release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Sticky illegal-mode flag; a new illegal beat outranks err_clr.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_r <= 1'b0;
    end else if (bad_beat_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  imm_ext_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   ({ext_s, in_mode}),
    .rdata   (rdata_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign out_data = rdata_s[ENTRY_W-1:3];
  assign out_mode = rdata_s[2:0];
  assign count    = count_s;
  assign err      = err_r;

endmodule

// File: tb/tb_imm_ext_queue.sv
// Scoreboard bench for imm_ext_queue (DATA_W=16, DEPTH=2). Expected entries
// are queued as beats are issued; a negedge monitor compares every entry the
// DUT offers while out_ready is high. Honours IMM_EXT_ZEXT_EN for TRAP8.
module tb_imm_ext_queue;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_ir = 16'h0000;
  logic [2:0]        in_mode = 3'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_mode;
  logic [CNT_W-1:0]  count;
  logic              err;
  logic              err_clr = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        mode;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  imm_ext_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .count     (count),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 Clk = ~Clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void enq(input logic [DATA_W-1:0] data, input logic [2:0] mode);
    exp_t e;
    e.data = data;
    e.mode = mode;
    exp_q.push_back(e);
  endfunction

  // Monitor: the head entry offered while out_ready is high is popped at the next edge.
  always @(negedge Clk) begin
    if (Reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h mode %0d with nothing expected", out_data, out_mode);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_mode", 32'(out_mode), 32'(mon_e.mode));
      end
    end
  end

  // Issue one beat; call just after a rising edge. Returns just after the handshake edge.
  task automatic push_beat(input logic [15:0] ir, input logic [2:0] mode);
    int n;
    in_valid = 1'b1;
    in_ir    = ir;
    in_mode  = mode;
    n = 0;
    @(negedge Clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge Clk);
    end
    check("push_handshake", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [15:0] vec_ir  [7] = '{16'h0010, 16'h001F, 16'h0100, 16'h0400, 16'h000F, 16'h03FF, 16'hFFE0};
  logic [2:0]  vec_md  [7] = '{3'd0,     3'd1,     3'd2,     3'd3,     3'd0,     3'd3,     3'd1};
  logic [15:0] vec_exp [7] = '{16'hFFF0, 16'h001F, 16'hFF00, 16'hFC00, 16'h000F, 16'h03FF, 16'hFFE0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    check("in_ready_release_cycle", 32'(in_ready), 32'd0);
    @(posedge Clk);
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // Extension values, one-cycle latency, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enq(vec_exp[i], vec_md[i]);
      push_beat(vec_ir[i], vec_md[i]);
      @(negedge Clk);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      check("latency_count", 32'(count), 32'd1);
      @(posedge Clk);
      #1;
    end

    // TRAP8
`ifdef IMM_EXT_ZEXT_EN
    enq(16'h00FF, 3'd4);
    push_beat(16'h00FF, 3'd4);
    @(negedge Clk);
    check("trap8_out_valid", 32'(out_valid), 32'd1);
    check("trap8_err", 32'(err), 32'd0);
    @(posedge Clk);
    #1;
`else
    push_beat(16'h00FF, 3'd4);
    @(negedge Clk);
    check("trap8_no_output", 32'(out_valid), 32'd0);
    check("trap8_count", 32'(count), 32'd0);
    check("trap8_err", 32'(err), 32'd1);
    @(posedge Clk);
    #1 err_clr = 1'b1;
    @(posedge Clk);
    #1 err_clr = 1'b0;
    @(negedge Clk);
    check("trap8_err_cleared", 32'(err), 32'd0);
    @(posedge Clk);
    #1;
`endif

    // Back-pressure: A, B fill the queue, C is held
    out_ready = 1'b0;
    enq(16'h0001, 3'd0);
    push_beat(16'h0001, 3'd0);
    enq(16'hFFE0, 3'd1);
    push_beat(16'h0020, 3'd1);
    @(negedge Clk);
    check("bp_count_full", 32'(count), 32'd2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge Clk);
    #1;
    enq(16'h00FF, 3'd2);
    in_valid = 1'b1;
    in_ir    = 16'h00FF;
    in_mode  = 3'd2;
    repeat (2) begin
      @(negedge Clk);
      check("bp_c_held", 32'(count), 32'd2);
    end
    @(posedge Clk);
    #1 out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;
    @(negedge Clk);
    check("bp_trace_1", 32'(count), 32'd1);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(negedge Clk);
    check("bp_trace_2", 32'(count), 32'd2);
    @(posedge Clk);
    #1 out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("bp_trace_3", 32'(count), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    check("bp_trace_4", 32'(count), 32'd0);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count=1
    @(posedge Clk);
    #1 out_ready = 1'b0;
    enq(16'hFD55, 3'd3);
    push_beat(16'h0555, 3'd3);
    @(negedge Clk);
    check("pp_count_before", 32'(count), 32'd1);
    @(posedge Clk);
    #1 out_ready = 1'b1;
    enq(16'hFFFE, 3'd0);
    push_beat(16'h001E, 3'd0);
    @(negedge Clk);
    check("pp_count_same", 32'(count), 32'd1);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check("pp_count_drained", 32'(count), 32'd0);

    // Illegal modes and err_clr
    @(posedge Clk);
    #1 out_ready = 1'b0;
    enq(16'h0003, 3'd1);
    push_beat(16'h0003, 3'd1);
    push_beat(16'h1234, 3'd7);
    @(negedge Clk);
    check("illegal_count_unchanged", 32'(count), 32'd1);
    check("illegal_err_set", 32'(err), 32'd1);
    @(posedge Clk);
    #1 err_clr = 1'b1;
    @(posedge Clk);
    #1 err_clr = 1'b0;
    @(negedge Clk);
    check("err_clr_pulse", 32'(err), 32'd0);
    @(posedge Clk);
    #1 err_clr = 1'b1;
    push_beat(16'h0000, 3'd5);
    err_clr = 1'b0;
    @(negedge Clk);
    check("err_set_wins", 32'(err), 32'd1);
    check("illegal_count_still", 32'(count), 32'd1);

    // Asynchronous reset with two entries held
    @(posedge Clk);
    #1;
    push_beat(16'h0007, 3'd0);
    @(negedge Clk);
    check("pre_reset_count", 32'(count), 32'd2);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b1;
    enq(16'h0005, 3'd0);
    push_beat(16'h0005, 3'd0);
    @(negedge Clk);
    check("post_reset_out_valid", 32'(out_valid), 32'd1);
    check("post_reset_count", 32'(count), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    check("post_reset_drained", 32'(count), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
